keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad. Drives the four column lines one at a time (active-low), samples the four row lines (active-low with pull-ups; all rows high means no key pressed), debounces a detected press, and reports the key as a 4-bit code with a one-cycle valid strobe. It sits between the keypad pins and the downstream key-consuming logic and replaces free-running combinational press detection with a sequenced, debounced event stream.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven (dwell); minimum 4.
- `DEBOUNCE_CYCLES`, default 20000: consecutive clock cycles a press must be stable before it is reported; minimum 2.
- `REPEAT_CYCLES`, default 5000000: auto-repeat period, used only when `KEYPAD_REPEAT_EN` is defined.
- `clk` in, 1 bit: system clock.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `row_n` in, 4 bits: raw keypad rows F0..F3, active-low, asynchronous to `clk`.
- `col_n` out, 4 bits: column drive, one-hot-low while scanning.
- `key_code` out, 4 bits: `{row_idx[1:0], col_idx[1:0]}` of the last reported key.
- `key_valid` out, 1 bit: one-cycle pulse when `key_code` is updated.
- `key_held` out, 1 bit: high while a debounced key remains pressed.

## Operation
- `row_n` passes through a 2-flop synchronizer; all decisions use the synchronized value `row_s`. `press = (row_s != 4'hF)`.
- Row encode: the lowest-index low row wins (row0 > row1 > row2 > row3).
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- **SCAN:** drive `col_n = ~(1<<col_idx)`; the dwell counter runs from 0 to SCAN_DIV-1.
  - On the last dwell cycle with `press` high: latch the encoded row, go to DEBOUNCE, and do not advance the column.
  - On the last dwell cycle with `press` low: advance `col_idx` (3 wraps to 0) and restart the dwell.
- **DEBOUNCE:** the column stays fixed. The counter counts consecutive cycles in which `press` is high and the encoded row equals the latched row.
  - On a mismatch or release: return to SCAN, restart the dwell on the same column, and report nothing.
  - When the counter reaches DEBOUNCE_CYCLES-1: load `key_code`, pulse `key_valid`, set `key_held`, and go to HELD.
- **HELD:** the column stays fixed. When `press` goes low, go to RELEASE. A change of row while still pressed is ignored; no new report.
- **RELEASE:** count consecutive cycles with `press` low up to DEBOUNCE_CYCLES-1, then clear `key_held`, advance the column and enter SCAN. Any `press` during the count returns to HELD without a new report.
- A second key pressed in another column during HELD is not seen until release, because that column is not driven.
- `key_code` holds its value between reports.
- Reset values: `col_n = 4'b1110`, `key_code = 4'h0`, `key_valid = 0`, `key_held = 0`, state SCAN, all counters 0, synchronizer flops reset to 1.
- Reset asserted mid-operation aborts immediately to these values; no `key_valid` is emitted.

## Timing
- Synchronizer latency: 2 cycles from `row_n` to `row_s`.
- Columns change only at dwell boundaries. The column is stable for SCAN_DIV cycles, which covers the 2-cycle synchronizer plus at least 2 settling cycles.
- Worst-case detect latency from a stable press to `key_valid`: 2 + 4·SCAN_DIV + DEBOUNCE_CYCLES cycles.
- `key_valid` is high for exactly one cycle, the same cycle in which `key_code` takes its new value. `key_held` rises in that same cycle.
- `key_held` falls DEBOUNCE_CYCLES cycles after `row_s` returns to 4'hF.
- All outputs are registered; no combinational path from `row_n` to any output.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
- **Defined:** in HELD, a repeat counter runs. Every REPEAT_CYCLES cycles it pulses `key_valid` again with the same `key_code`. The first repeat comes REPEAT_CYCLES cycles after the initial report. The counter clears on leaving HELD, and returning to HELD from RELEASE restarts it from 0.
- **Undefined:** the repeat counter and its logic are absent. Exactly one `key_valid` per press.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32.
- **Reset and idle:** `rst_n` low then high, `row_n = 4'hF` for 64 cycles. Expect `col_n` cycling 1110→1101→1011→0111→1110 every 4 cycles, and `key_valid`/`key_held` never high.
- **Clean press:** row1 pulled low only while `col_n = 4'b1011`, held for 40 cycles. Expect exactly one `key_valid` with `key_code = 4'b0110`. `key_held` falls 8 cycles after release, then scanning resumes at col3.
- **Bounce:** row2 on col0 toggling every 3 cycles for 30 cycles, then stable for 20 cycles. Expect no report during bouncing, then a single `key_valid` with `key_code = 4'b1000`.
- **Multi-row and wrap:** rows 0 and 3 both low on col3. Expect `key_code = 4'b0011` (lowest row wins). After release, the column wraps to col0.
- **Reset mid-debounce:** assert `rst_n` low 4 cycles into DEBOUNCE. Expect outputs at reset values immediately and no `key_valid`.
- **Repeat (`KEYPAD_REPEAT_EN` only):** press held for 100 cycles after the report. Expect repeat pulses at +32, +64 and +96 cycles with the same code. Without the macro, expect one pulse only.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column drive, 2-flop row sync, debounce, one-cycle key strobe.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned CntMax = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4) begin : g_chk_scan
        $error("SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_chk_rep
        $error("REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      row_meta_q, row_meta_d;
    logic [3:0]      row_s_q, row_s_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_n_q, col_n_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      row_lat_q, row_lat_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;
    logic            press;
    logic [1:0]      row_enc;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);
    logic [RepW-1:0] rep_q, rep_d;
`endif

    assign press = (row_s_q != 4'hF);

    // Lowest-index low row wins when several rows are pulled down.
    always_comb begin
        row_enc = 2'd3;
        if (!row_s_q[0]) begin
            row_enc = 2'd0;
        end else if (!row_s_q[1]) begin
            row_enc = 2'd1;
        end else if (!row_s_q[2]) begin
            row_enc = 2'd2;
        end
    end

    always_comb begin
        row_meta_d  = row_n;
        row_s_d     = row_meta_q;
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        row_lat_d   = row_lat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = '0;
`endif

        unique case (state_q)
            StScan: begin
                if (cnt_q == ScanLast) begin
                    cnt_d = '0;
                    if (press) begin
                        row_lat_d = row_enc;
                        state_d   = StDebounce;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDebounce: begin
                if (!press || (row_enc != row_lat_q)) begin
                    state_d = StScan;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    key_code_d  = {row_lat_q, col_idx_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = StHeld;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                // The cycle that first sees release already counts toward the release run.
                if (!press) begin
                    state_d = StRelease;
                    cnt_d   = CntW'(1);
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_q == RepLast) begin
                    key_valid_d = 1'b1;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            StRelease: begin
                if (press) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    state_d    = StScan;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StScan;
                cnt_d   = '0;
            end
        endcase

        col_n_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            state_q     <= StScan;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            cnt_q       <= '0;
            row_lat_q   <= 2'd0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            row_meta_q  <= row_meta_d;
            row_s_q     <= row_s_d;
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            cnt_q       <= cnt_d;
            row_lat_q   <= row_lat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a simulated key matrix answers the DUT column drive and a
// cycle-level behavioural model of the scanning rules predicts every output.
module tb_keypad_scan_ctrl;

    localparam int unsigned ScanDiv = 4;
    localparam int unsigned Deb     = 8;
    localparam int unsigned Rep     = 32;

    localparam int PhScan = 0;
    localparam int PhDeb  = 1;
    localparam int PhHeld = 2;
    localparam int PhRel  = 3;

`ifdef KEYPAD_REPEAT_EN
    localparam bit RepOn = 1'b1;
`else
    localparam bit RepOn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row_n = 4'hF;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [9:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Pressed switches in the matrix, index row*4+col.
    bit keys [16];

    // Reference model state.
    logic [3:0] m_s1, m_s2;
    int         m_col, m_phase, m_dwell, m_run, m_row, m_rep;
    logic [3:0] m_code;
    bit         m_valid, m_held;

    keypad_scan_ctrl #(
        .SCAN_DIV        (ScanDiv),
        .DEBOUNCE_CYCLES (Deb),
        .REPEAT_CYCLES   (Rep)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    assign dut_vec = {col_n, key_code, key_valid, key_held};

    function automatic logic [3:0] keypad_rows(input logic [3:0] cols);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (keys[rr*4+cc] && !cols[cc]) r[rr] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic int lowest_low_row(input logic [3:0] s);
        for (int r = 0; r < 4; r++) begin
            if (!s[r]) return r;
        end
        return -1;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [3:0] one;
        one = 4'b0001;
        return {~(one << m_col), m_code, m_valid, m_held};
    endfunction

    task automatic model_reset();
        m_s1 = 4'hF; m_s2 = 4'hF;
        m_col = 0; m_phase = PhScan; m_dwell = 0; m_run = 0; m_row = 0; m_rep = 0;
        m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] rin);
        int  low;
        bit  press;
        low   = lowest_low_row(m_s2);
        press = (low >= 0);
        m_valid = 1'b0;
        case (m_phase)
            PhScan: begin
                m_dwell++;
                if (m_dwell == ScanDiv) begin
                    m_dwell = 0;
                    if (press) begin
                        m_phase = PhDeb; m_row = low; m_run = 0;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
            end
            PhDeb: begin
                if (press && low == m_row) begin
                    m_run++;
                    if (m_run == Deb) begin
                        m_code = 4'(m_row * 4 + m_col);
                        m_valid = 1'b1; m_held = 1'b1; m_phase = PhHeld; m_rep = 0;
                    end
                end else begin
                    m_phase = PhScan; m_dwell = 0;
                end
            end
            PhHeld: begin
                if (!press) begin
                    m_phase = PhRel; m_run = 1;
                end else if (RepOn) begin
                    m_rep++;
                    if (m_rep == Rep) begin
                        m_valid = 1'b1; m_rep = 0;
                    end
                end
            end
            default: begin
                if (press) begin
                    m_phase = PhHeld; m_rep = 0;
                end else begin
                    m_run++;
                    if (m_run == Deb) begin
                        m_held = 1'b0; m_col = (m_col + 1) % 4; m_phase = PhScan; m_dwell = 0;
                    end
                end
            end
        endcase
        m_s2 = m_s1;
        m_s1 = rin;
    endtask

    // One clock: DUT and model consume the same row_n, then the matrix answers the new column.
    task automatic cycle();
        logic [3:0] rin;
        rin = row_n;
        @(posedge clk);
        model_step(rin);
        #1;
        row_n = keypad_rows(col_n);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) keys[i] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (col_n !== 4'b1110) begin
            n_fail++; $display("FAIL reset_col_n: got %b want 1110", col_n);
        end
        n_checks++;
        if (key_code !== 4'h0) begin
            n_fail++; $display("FAIL reset_key_code: got %h want 0", key_code);
        end
        n_checks++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid);
        end
        n_checks++;
        if (key_held !== 1'b0) begin
            n_fail++; $display("FAIL reset_key_held: got %b want 0", key_held);
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        row_n = 4'hF;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        logic [3:0] want_col;
        logic [3:0] one;
        one = 4'b0001;
        for (int k = 1; k <= 64; k++) begin
            cycle();
            want_col = ~(one << ((k / 4) % 4));
            n_checks++;
            if (col_n !== want_col || key_valid !== 1'b0 || key_held !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got col=%b v=%b h=%b want col=%b v=0 h=0",
                         k, col_n, key_valid, key_held, want_col);
            end
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL idle_model: got %b want %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        int         pulses;
        bit         seen;
        bit         prev_held;
        logic [3:0] code;
        pulses = 0; seen = 1'b0; code = 4'h0;
        keys[1*4+2] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL clean_detect: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) begin
                seen = 1'b1; pulses++; code = key_code;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL clean_timeout: key_valid=0 after 60 cycles, want a pulse");
        end
        repeat (40) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL clean_hold: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) pulses++;
        end
        keys[1*4+2] = 1'b0;
        prev_held = key_held;
        repeat (40) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL clean_release: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) pulses++;
            if (prev_held && !key_held) begin
                n_checks++;
                if (col_n !== 4'b0111) begin
                    n_fail++; $display("FAIL clean_resume_col: got %b want 0111", col_n);
                end
            end
            prev_held = key_held;
        end
        n_checks++;
        if (code !== 4'b0110) begin
            n_fail++; $display("FAIL clean_code: got %b want 0110", code);
        end
        n_checks++;
        if (pulses !== (RepOn ? 2 : 1)) begin
            n_fail++; $display("FAIL clean_pulses: got %0d want %0d", pulses, RepOn ? 2 : 1);
        end
    endtask

    task automatic test_bounce();
        int         pulses;
        logic [3:0] code;
        pulses = 0; code = 4'h0;
        for (int i = 0; i < 30; i++) begin
            keys[2*4+0] = ((i / 3) % 2 == 0);
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_model: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL bounce_no_report: got %0d pulses want 0", pulses);
        end
        keys[2*4+0] = 1'b1;
        repeat (40) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_stable: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) begin
                pulses++; code = key_code;
            end
        end
        n_checks++;
        if (pulses !== 1 || code !== 4'b1000) begin
            n_fail++;
            $display("FAIL bounce_report: got %0d pulses code %b want 1 pulse code 1000",
                     pulses, code);
        end
        keys[2*4+0] = 1'b0;
        repeat (40) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL bounce_release: got %b want %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_multi_row();
        bit         seen;
        bit         prev_held;
        logic [3:0] code;
        seen = 1'b0; code = 4'h0;
        keys[0*4+3] = 1'b1;
        keys[3*4+3] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL multi_detect: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) begin
                seen = 1'b1; code = key_code;
            end
        end
        n_checks++;
        if (!seen || code !== 4'b0011) begin
            n_fail++; $display("FAIL multi_code: seen=%b code=%b want seen=1 code=0011", seen, code);
        end
        repeat (10) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL multi_hold: got %b want %b", dut_vec, exp_vec());
            end
        end
        keys[0*4+3] = 1'b0;
        keys[3*4+3] = 1'b0;
        prev_held = key_held;
        repeat (30) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL multi_release: got %b want %b", dut_vec, exp_vec());
            end
            if (prev_held && !key_held) begin
                n_checks++;
                if (col_n !== 4'b1110) begin
                    n_fail++; $display("FAIL multi_wrap_col: got %b want 1110", col_n);
                end
            end
            prev_held = key_held;
        end
    endtask

    task automatic test_repeat();
        bit seen;
        int reps;
        seen = 1'b0; reps = 0;
        keys[3*4+1] = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL repeat_detect: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL repeat_timeout: key_valid=0 after 60 cycles, want a pulse");
        end
        for (int k = 1; k <= 100; k++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL repeat_model: got %b want %b", dut_vec, exp_vec());
            end
            if (key_valid) begin
                reps++;
                n_checks++;
                if (k !== 32 * reps || key_code !== 4'b1101) begin
                    n_fail++;
                    $display("FAIL repeat_pulse: at +%0d code %b want +%0d code 1101",
                             k, key_code, 32 * reps);
                end
            end
        end
        n_checks++;
        if (reps !== (RepOn ? 3 : 0)) begin
            n_fail++; $display("FAIL repeat_count: got %0d want %0d", reps, RepOn ? 3 : 0);
        end
        keys[3*4+1] = 1'b0;
        repeat (40) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL repeat_release: got %b want %b", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        bit reached;
        reached = 1'b0;
        keys[0] = 1'b1;
        for (int i = 0; i < 80 && !reached; i++) begin
            cycle();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL midrst_model: got %b want %b", dut_vec, exp_vec());
            end
            if (m_phase == PhDeb && m_run == 4) reached = 1'b1;
        end
        n_checks++;
        if (!reached) begin
            n_fail++; $display("FAIL midrst_timeout: debounce not reached in 80 cycles");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL midrst_outputs: got %b want 1110000000", dut_vec);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_hold: got v=%b h=%b want v=0 h=0", key_valid, key_held);
            end
        end
        keys[0] = 1'b0;
        model_reset();
        row_n = 4'hF;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int  idx [2];
        int  nk;
        int  hold_len;
        int  rel_len;
        bit  bouncy;
        for (int it = 0; it < 10; it++) begin
            nk       = int'($urandom_range(1, 2));
            idx[0]   = int'($urandom_range(0, 15));
            idx[1]   = int'($urandom_range(0, 15));
            bouncy   = 1'($urandom_range(0, 1));
            hold_len = int'($urandom_range(5, 80));
            rel_len  = int'($urandom_range(5, 50));
            for (int i = 0; i < hold_len; i++) begin
                for (int j = 0; j < nk; j++) begin
                    keys[idx[j]] = !(bouncy && i < 12 && (i % 4 == 3));
                end
                cycle();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_press it%0d: got %b want %b", it, dut_vec, exp_vec());
                end
            end
            for (int j = 0; j < 16; j++) keys[j] = 1'b0;
            for (int i = 0; i < rel_len; i++) begin
                cycle();
                n_checks++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL random_release it%0d: got %b want %b", it, dut_vec, exp_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_multi_row();
        test_repeat();
        test_reset_mid_debounce();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
